// File: rtl/alu_issue_unit.sv
// Issue front-end for the combinational ALU: latches one request, lets the ALU settle for
// AluLatency cycles, captures result/flags into a held response and owns the flags register.
module alu_issue_unit #(
    parameter int unsigned L           = 16,
    parameter int unsigned P           = 0,
    parameter int unsigned AluLatency  = 1,
    parameter logic [15:0] OpCountInit = 16'h0000  // reset value of the completion counter
) (
    input  logic         Clock,
    input  logic         ResetN,
    input  logic         ReqValid,
    output logic         ReqReady,
    input  logic [P:0]   ReqOp,
    input  logic [L-1:0] ReqB,
    input  logic [L-1:0] ReqC,
    input  logic         ReqClrFlags,
    output logic         RspValid,
    input  logic         RspReady,
    output logic [L-1:0] RspRes,
    output logic [L-1:0] RspFlags,
    output logic [P:0]   AluOperation,
    output logic [L-1:0] AluB,
    output logic [L-1:0] AluC,
    output logic [L-1:0] AluFlagsIn,
    input  logic [L-1:0] AluRes,
    input  logic [L-1:0] AluFlagsOut,
    output logic [L-1:0] Flags,
    output logic [15:0]  OpCount
);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e       state_q, state_d;
    logic [P:0]   op_q, op_d;
    logic [L-1:0] b_q, b_d, c_q, c_d, fin_q, fin_d;
    logic [L-1:0] res_q, res_d, rflags_q, rflags_d, flags_q, flags_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [15:0]  count_q, count_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic         load;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        b_d         = b_q;
        c_d         = c_q;
        fin_d       = fin_q;
        res_d       = res_q;
        rflags_d    = rflags_q;
        flags_d     = flags_q;
        cnt_d       = cnt_q;
        count_d     = count_q;
        rsp_valid_d = rsp_valid_q;
        ReqReady    = 1'b0;
        load        = 1'b0;

        unique case (state_q)
            StIdle: begin
                ReqReady = 1'b1;
                if (ReqValid) begin
                    load    = 1'b1;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (cnt_q == 4'd0) begin
                    res_d       = AluRes;
                    rflags_d    = AluFlagsOut;
                    flags_d     = AluFlagsOut;
                    rsp_valid_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                // A new request may only enter on the edge that frees the response slot.
                ReqReady = RspReady;
                if (RspReady) begin
                    rsp_valid_d = 1'b0;
                    count_d     = count_q + 16'd1;
                    if (ReqValid) begin
                        load    = 1'b1;
                        state_d = StExec;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            op_d  = ReqOp;
            b_d   = ReqB;
            c_d   = ReqC;
            fin_d = ReqClrFlags ? '0 : flags_q;
            cnt_d = 4'(AluLatency - 1);
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q     <= StIdle;
            op_q        <= '0;
            b_q         <= '0;
            c_q         <= '0;
            fin_q       <= '0;
            res_q       <= '0;
            rflags_q    <= '0;
            flags_q     <= '0;
            cnt_q       <= '0;
            count_q     <= OpCountInit;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            b_q         <= b_d;
            c_q         <= c_d;
            fin_q       <= fin_d;
            res_q       <= res_d;
            rflags_q    <= rflags_d;
            flags_q     <= flags_d;
            cnt_q       <= cnt_d;
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign RspValid     = rsp_valid_q;
    assign RspRes       = res_q;
    assign RspFlags     = rflags_q;
    assign AluOperation = op_q;
    assign AluB         = b_q;
    assign AluC         = c_q;
    assign AluFlagsIn   = fin_q;
    assign Flags        = flags_q;
    assign OpCount      = count_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit: one unit on a divide/multiply ALU model (latency 1) and
// one with latency 4 whose ALU outputs are driven directly.
module tb_alu_issue_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [0:0]  op = '0;
    logic [15:0] rb = '0, rc = '0;
    logic        clr = 1'b0;

    logic        a_valid = 1'b0, a_rdy = 1'b0, a_stub = 1'b0;
    logic        a_req_ready, a_rsp_valid;
    logic [15:0] a_rsp_res, a_rsp_flags, a_b, a_c, a_fin, a_flags, a_cnt;
    logic [0:0]  a_op;
    logic [15:0] a_res, a_fout;

    logic        b_valid = 1'b0, b_rdy = 1'b0;
    logic        b_req_ready, b_rsp_valid;
    logic [15:0] b_rsp_res, b_rsp_flags, b_b, b_c, b_fin, b_flags, b_cnt;
    logic [0:0]  b_op;
    logic [15:0] b_alu_res = 16'h0000;
    logic [15:0] b_fout = 16'h0042;

    int total = 0, passed = 0, failed = 0;

    always #5 clk = ~clk;

    // Reference ALU: op 0 divides, op 1 multiplies; flags are the result sign or a +1 stub.
    always_comb begin
        a_res = 16'h0000;
        if (a_op == 1'b0) a_res = (a_c != 0) ? 16'($signed(a_b) / $signed(a_c)) : 16'hFFFF;
        else              a_res = 16'($signed(a_b) * $signed(a_c));
        a_fout = a_stub ? a_fin + 16'd1 : {15'd0, a_res[15]};
    end

    alu_issue_unit #(.L(16), .P(0), .AluLatency(1)) u_a (
        .Clock(clk), .ResetN(rst_n), .ReqValid(a_valid), .ReqReady(a_req_ready),
        .ReqOp(op), .ReqB(rb), .ReqC(rc), .ReqClrFlags(clr),
        .RspValid(a_rsp_valid), .RspReady(a_rdy), .RspRes(a_rsp_res), .RspFlags(a_rsp_flags),
        .AluOperation(a_op), .AluB(a_b), .AluC(a_c), .AluFlagsIn(a_fin),
        .AluRes(a_res), .AluFlagsOut(a_fout), .Flags(a_flags), .OpCount(a_cnt)
    );

    alu_issue_unit #(.L(16), .P(0), .AluLatency(4), .OpCountInit(16'hFFFE)) u_b (
        .Clock(clk), .ResetN(rst_n), .ReqValid(b_valid), .ReqReady(b_req_ready),
        .ReqOp(op), .ReqB(rb), .ReqC(rc), .ReqClrFlags(clr),
        .RspValid(b_rsp_valid), .RspReady(b_rdy), .RspRes(b_rsp_res), .RspFlags(b_rsp_flags),
        .AluOperation(b_op), .AluB(b_b), .AluC(b_c), .AluFlagsIn(b_fin),
        .AluRes(b_alu_res), .AluFlagsOut(b_fout), .Flags(b_flags), .OpCount(b_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        check("rst_req_ready", 32'(a_req_ready), 1);
        check("rst_rsp_valid", 32'(a_rsp_valid), 0);
        check("rst_rsp_res", 32'(a_rsp_res), 0);
        check("rst_flags", 32'(a_flags), 0);
        check("rst_opcount", 32'(a_cnt), 0);
        check("rst_alu_b", 32'(a_b), 0);
        check("rst_alu_fin", 32'(a_fin), 0);
        #11 rst_n = 1'b1;
        tick();

        // 6 / 3 with latency 1
        op = 1'b0; rb = 16'd6; rc = 16'd3; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        check("t1_exec_b", 32'(a_b), 6);
        check("t1_exec_c", 32'(a_c), 3);
        check("t1_exec_ready", 32'(a_req_ready), 0);
        check("t1_exec_rspv", 32'(a_rsp_valid), 0);
        tick();
        check("t1_rspv", 32'(a_rsp_valid), 1);
        check("t1_res", 32'(a_rsp_res), 2);
        check("t1_done_ready_lo", 32'(a_req_ready), 0);
        a_rdy = 1'b1;
        #1 check("t1_done_ready_hi", 32'(a_req_ready), 1);
        tick();
        a_rdy = 1'b0;
        check("t1_opcount", 32'(a_cnt), 1);
        check("t1_rspv_cleared", 32'(a_rsp_valid), 0);

        // -16 * -1 under response backpressure; a second request waits
        op = 1'b1; rb = 16'hFFF0; rc = 16'hFFFF; a_valid = 1'b1;
        tick();
        rb = 16'd7; rc = 16'd2;
        tick();
        check("t2_res", 32'(a_rsp_res), 16);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_rspv", 32'(a_rsp_valid), 1);
            check("t2_hold_res", 32'(a_rsp_res), 16);
            check("t2_hold_ready", 32'(a_req_ready), 0);
            check("t2_hold_alu_b", 32'(a_b), 16'hFFF0);
        end
        a_rdy = 1'b1;
        tick();
        a_valid = 1'b0; a_rdy = 1'b0;
        check("t2_handoff_b", 32'(a_b), 7);
        check("t2_opcount", 32'(a_cnt), 2);
        tick();
        check("t2_second_res", 32'(a_rsp_res), 14);
        a_rdy = 1'b1;
        tick();
        a_rdy = 1'b0;
        check("t2_opcount_b", 32'(a_cnt), 3);

        // Negative product sets the sign flag, then reset lands mid-EXEC
        op = 1'b1; rb = 16'hFFFE; rc = 16'd3; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        tick();
        check("t3_res", 32'(a_rsp_res), 16'hFFFA);
        check("t3_flags", 32'(a_flags), 1);
        a_rdy = 1'b1;
        tick();
        a_rdy = 1'b0;
        op = 1'b0; rb = 16'd9; rc = 16'd3; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t3_rst_rspv", 32'(a_rsp_valid), 0);
        check("t3_rst_flags", 32'(a_flags), 0);
        check("t3_rst_opcount", 32'(a_cnt), 0);
        check("t3_rst_alu_b", 32'(a_b), 0);
        check("t3_rst_res", 32'(a_rsp_res), 0);
        check("t3_rst_ready", 32'(a_req_ready), 1);
        check("t3_rst_b_opcount", 32'(b_cnt), 16'hFFFE);
        tick();
        check("t3_rst_hold_rspv", 32'(a_rsp_valid), 0);
        rst_n = 1'b1;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        tick();
        check("t3_after_res", 32'(a_rsp_res), 3);
        a_rdy = 1'b1;
        tick();
        a_rdy = 1'b0;
        check("t3_after_opcount", 32'(a_cnt), 1);

        // Flags feedback with back-to-back DONE handoff, then a cleared-flags op
        a_stub = 1'b1; a_valid = 1'b1; a_rdy = 1'b1;
        tick();
        check("t4_fin0", 32'(a_fin), 0);
        tick();
        check("t4_flags1", 32'(a_flags), 1);
        tick();
        check("t4_fin1", 32'(a_fin), 1);
        tick();
        check("t4_flags2", 32'(a_flags), 2);
        tick();
        check("t4_fin2", 32'(a_fin), 2);
        tick();
        check("t4_flags3", 32'(a_flags), 3);
        clr = 1'b1;
        tick();
        a_valid = 1'b0;
        check("t4_clr_fin", 32'(a_fin), 0);
        check("t4_clr_flags_kept", 32'(a_flags), 3);
        tick();
        check("t4_clr_flags", 32'(a_flags), 1);
        check("t4_clr_rspflags", 32'(a_rsp_flags), 1);
        tick();
        a_rdy = 1'b0; clr = 1'b0; a_stub = 1'b0;
        check("t4_opcount", 32'(a_cnt), 5);

        // Latency 4: operands held, sampling on E0+4 only
        op = 1'b1; rb = 16'h1234; rc = 16'h5678; b_valid = 1'b1; b_alu_res = 16'hDEAD;
        tick();
        b_valid = 1'b0; rb = 16'hAAAA; rc = 16'h5555;
        for (int i = 0; i < 4; i++) begin
            check("t5_hold_b", 32'(b_b), 16'h1234);
            check("t5_hold_c", 32'(b_c), 16'h5678);
            check("t5_no_rspv", 32'(b_rsp_valid), 0);
            if (i == 3) b_alu_res = 16'hBEEF;
            tick();
        end
        check("t5_rspv", 32'(b_rsp_valid), 1);
        check("t5_res", 32'(b_rsp_res), 16'hBEEF);
        check("t5_rspflags", 32'(b_rsp_flags), 16'h0042);
        b_rdy = 1'b1;
        tick();
        check("t6_opcount_ffff", 32'(b_cnt), 16'hFFFF);
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("t6_rspv", 32'(b_rsp_valid), 1);
        tick();
        b_rdy = 1'b0;
        check("t6_opcount_wrap", 32'(b_cnt), 0);
        check("t6_rspv_cleared", 32'(b_rsp_valid), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
